cdc_host_ctrl: RTL and testbench
================================

Name: cdc_host_ctrl

Overview:
Parametrised successor to the NeoCD LC8951 host-chip model.
Provides the 68k-facing indirect register file with working command and status FIFOs (COMIN/SBOUT), a live transfer byte counter and address driven by the DMA engine, a real transfer-end interrupt, and a parametrised decoder-IRQ pulse.
Sits between the 68k bus decode and the CD sector buffer / DMA logic.

Parameters:
INT_CYCLES, 21600, CLK_EN ticks that the decoder IRQ (nVALST low) stays asserted after a sector.
CMD_DEPTH, 8, command FIFO depth in bytes; power of two, at least 2.
STAT_DEPTH, 8, status FIFO depth in bytes; power of two, at least 2.
DBC_W, 12, transfer byte counter width, 12 to 16.

Ports:
clk_sys  in  1  system clock
nRESET  in  1  asynchronous active-low reset
CLK_EN  in  1  68k clock enable; all state advances only when high
nWR, nRD  in  1 each  68k strobes, acted on at their falling edge
RS  in  1  0 = address register, 1 = pointed register
DIN  in  8  write data
DOUT  out  8  read data
HEADER_DIN  in  32  sector header bytes {H3,H2,H1,H0}
SECTOR_READY  in  1  rising edge = decoded sector available
XFER_STB  in  1  one byte moved by DMA; single CLK_EN tick
XFER_ACT  out  1  transfer in progress (equals ~nDTBSY)
XFER_ADDR  out  16  current DAC
CMD_DOUT  out  8  head of command FIFO
CMD_VALID  out  1  command FIFO not empty
CMD_POP  in  1  consume CMD_DOUT
STAT_DIN  in  8  status byte from the drive side
STAT_PUSH  in  1  push STAT_DIN
STAT_FULL  out  1  status FIFO full
CDC_nIRQ  out  1  active-low interrupt, registered

Behaviour:
- Reset values:
  - AR=0, DOUT=0, DBC=0, DAC=0, WA=0.
  - All IFCTRL, CTRL0 and CTRL1 bits 0.
  - All flags 0; nDTBSY, nSTBSY, nDTEN, nSTEN and nVALST all 1.
  - HEAD=0, both FIFOs empty, CDC_nIRQ=1, IRQ counter 0, edge registers 1 (nWR/nRD) and 0 (SECTOR_READY).
  - Reset mid-transfer aborts the transfer immediately; no DTEI is raised.
- Bus access:
  - Falling edges of nWR and nRD are detected via previous-value registers sampled on CLK_EN.
  - RS=0: a write loads AR=DIN[3:0]; a read returns {4'b0,AR}.
  - RS=1: access the register at AR, then AR increments (wrapping 15 to 0) if AR≠0. AR=0 never increments.
  - DOUT updates one CLK_EN tick after the nRD fall and holds until the next read.
- Write map:
  - 0 COMIN: push DIN to the command FIFO; dropped if the FIFO is full.
  - 1 IFCTRL: {CMDIEN,DTEIEN,DECIEN,nCMDBRK,nDTWAI,nSTWAI,DOUTEN,SOUTEN}.
  - 2/3 DBC low/high; the high write uses DIN[DBC_W-9:0].
  - 4/5 DAC low/high.
  - 6 DTTRG: if DOUTEN=1 and not busy, set nDTBSY=0; ignored while busy.
  - 7 DTACK: clear DTEI.
  - 8/9 WA.
  - 10 CTRL0: {DECEN,...}.
  - 11 CTRL1: bits [7:2,0].
  - 12–15: no effect.
  - Writes to DBC and DAC while busy are ignored.
- Read map:
  - 0 SBOUT: pop the status FIFO; returns 0x00 with no pop when empty.
  - 1 IFSTAT: {~CMDI,~DTEI,~DECI,1,nDTBSY,nSTBSY,nDTEN,nSTEN}.
  - 2 DBC[7:0].
  - 3 {DTEI replicated, DBC high bits}, zero-extended to 8 bits.
  - 4–7 HEAD0–3.
  - 8/9 0x04/0x00.
  - 10/11 WA.
  - 12 0x80; 13/14 0x00.
  - 15 {nVALST,7'b0}; this read clears DECI.
- Transfer state machine, IDLE→BUSY:
  - Enter BUSY on a valid DTTRG.
  - In BUSY, each XFER_STB: DAC+1 (wrapping at 16 bits).
  - If DBC≠0: DBC−1.
  - If DBC==0: this is the last byte. DBC wraps to all-ones, set DTEI=1 and nDTBSY=1, return to IDLE.
  - A transfer therefore moves DBC+1 bytes.
  - XFER_STB in IDLE is ignored.
- Decoder IRQ:
  - On a SECTOR_READY rise with DECEN=1: DECI=1, nVALST=0, counter=0, HEAD latched from HEADER_DIN.
  - Otherwise, while nVALST=0, the counter increments each tick; at INT_CYCLES, DECI=0 and nVALST=1.
  - A sector rising in the same tick as a STAT3 read leaves DECI=1 (set wins).
- CMDI is level-driven: CMDI = status FIFO not empty.
- CDC_nIRQ <= ~((CMDI&CMDIEN)|(DTEI&DTEIEN)|(DECI&DECIEN)), updated every tick; one tick of latency.
- FIFO rules:
  - Synchronous, first-word fall-through.
  - Pop when empty and push when full are ignored.
  - Simultaneous push and pop when full: both take effect and the count is unchanged.
  - Simultaneous push and pop when empty: push only.

Test Plan:
- **Decoder IRQ:** reset, write AR=10 then 0x80 (DECEN), AR=1 then 0x20 (DECIEN); pulse SECTOR_READY with HEADER_DIN=0x01000234 → CDC_nIRQ=0 one tick later. Reads of AR=4..7 return 34,02,00,01. IRQ releases after exactly 21600 ticks.
- **Transfer end:** set DOUTEN+DTEIEN, DBC=0x003, DAC=0x1000, DTTRG; issue 4 XFER_STB → XFER_ADDR=0x1004, DBC=0xFFF, XFER_ACT=0, CDC_nIRQ=0. DBCH read=0xFF. DTACK write → CDC_nIRQ=1.
- **Command FIFO overflow:** write 9 bytes to COMIN → CMD_VALID=1, pops return the first 8 bytes in order, 9th dropped.
- **Status FIFO:** push 0xA5 with CMDIEN=1 → CDC_nIRQ=0. SBOUT read=0xA5, then IRQ deasserts. A further SBOUT read returns 0x00.
- **Collision:** STAT3 read coincident with a SECTOR_READY rise → DECI stays 1. DTTRG while busy does not restart DBC.
- **Async reset mid-transfer:** pull nRESET low with no clock edge → CDC_nIRQ=1, XFER_ACT=0, DOUT=0 immediately.

Source files
------------

// File: rtl/cdc_host_ctrl.sv
// LC8951-style CDC host interface: indirect 68k register file, command/status
// FIFOs, DMA byte counter/address with transfer-end IRQ, and decoder IRQ pulse.

module cdc_host_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk_sys,
   input  logic       nRESET,
   input  logic       i_push,
   input  logic       i_pop,
   input  logic [7:0] i_din,
   output logic [7:0] o_dout,
   output logic       o_empty,
   output logic       o_full
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [AW:0]   r_cnt;
   logic          w_push;
   logic          w_pop;

   assign o_empty = (r_cnt == '0);
   assign o_full  = (r_cnt == (AW+1)'(DEPTH));
   assign o_dout  = r_mem[r_rp];

   // a pop frees the slot, so push-while-full is accepted only alongside a pop
   assign w_pop  = i_pop & ~o_empty;
   assign w_push = i_push & (~o_full | w_pop);

   always_ff @(posedge clk_sys) begin
      if (w_push) r_mem[r_wp] <= i_din;
   end

   always_ff @(posedge clk_sys or negedge nRESET) begin
      if (!nRESET) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop)  r_rp <= r_rp + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end
endmodule

module cdc_host_ctrl #(
   parameter int INT_CYCLES = 21600,
   parameter int CMD_DEPTH  = 8,
   parameter int STAT_DEPTH = 8,
   parameter int DBC_W      = 12
) (
   input  logic        clk_sys,
   input  logic        nRESET,
   input  logic        CLK_EN,
   input  logic        nWR,
   input  logic        nRD,
   input  logic        RS,
   input  logic [7:0]  DIN,
   output logic [7:0]  DOUT,
   input  logic [31:0] HEADER_DIN,
   input  logic        SECTOR_READY,
   input  logic        XFER_STB,
   output logic        XFER_ACT,
   output logic [15:0] XFER_ADDR,
   output logic [7:0]  CMD_DOUT,
   output logic        CMD_VALID,
   input  logic        CMD_POP,
   input  logic [7:0]  STAT_DIN,
   input  logic        STAT_PUSH,
   output logic        STAT_FULL,
   output logic        CDC_nIRQ
);
   localparam int CW = $clog2(INT_CYCLES + 1);
   // DTEI fills the DBCH bits above the counter's high part
   localparam logic [7:0] DTEI_MASK = 8'(~((16'd1 << (DBC_W - 8)) - 16'd1));

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} st_t;

   st_t              r_st;
   st_t              w_st_nxt;
   logic             r_nwr_d, r_nrd_d, r_sr_d;
   logic [3:0]       r_ar;
   logic [7:0]       r_dout;
   logic [DBC_W-1:0] r_dbc;
   logic [15:0]      r_dac;
   logic [15:0]      r_wa;
   logic             r_cmdien, r_dteien, r_decien, r_douten, r_decen;
   logic             r_dtei, r_deci, r_nvalst, r_nirq;
   logic [CW-1:0]    r_cnt;
   logic [31:0]      r_head;

   logic             w_wr, w_rd, w_wr1, w_rd1;
   logic [15:0]      w_we;
   logic             w_busy, w_trg, w_stb, w_last, w_rise, w_cmdi;
   logic             w_cmd_empty, w_cmd_full, w_cmd_push, w_cmd_pop;
   logic             w_st_empty, w_st_full;
   logic [7:0]       w_st_dout;
   logic [7:0]       w_ifstat, w_dbch, w_rdata;

   assign w_wr   = CLK_EN & r_nwr_d & ~nWR;
   assign w_rd   = CLK_EN & r_nrd_d & ~nRD;
   assign w_wr1  = w_wr & RS;
   assign w_rd1  = w_rd & RS;
   assign w_we   = w_wr1 ? (16'd1 << r_ar) : 16'd0;

   assign w_busy = (r_st == S_BUSY);
   assign w_trg  = w_we[6] & r_douten & ~w_busy;
   assign w_stb  = CLK_EN & XFER_STB & w_busy;
   assign w_last = w_stb & (r_dbc == '0);
   assign w_rise = CLK_EN & SECTOR_READY & ~r_sr_d;
   assign w_cmdi = ~w_st_empty;

   assign w_cmd_pop  = CLK_EN & CMD_POP;
   assign w_cmd_push = w_we[0] & (~w_cmd_full | (w_cmd_pop & ~w_cmd_empty));

   cdc_host_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .clk_sys (clk_sys),
      .nRESET  (nRESET),
      .i_push  (w_cmd_push),
      .i_pop   (w_cmd_pop),
      .i_din   (DIN),
      .o_dout  (CMD_DOUT),
      .o_empty (w_cmd_empty),
      .o_full  (w_cmd_full)
   );

   cdc_host_fifo #(.DEPTH(STAT_DEPTH)) u_stat_fifo (
      .clk_sys (clk_sys),
      .nRESET  (nRESET),
      .i_push  (CLK_EN & STAT_PUSH),
      .i_pop   (w_rd1 & (r_ar == 4'd0)),
      .i_din   (STAT_DIN),
      .o_dout  (w_st_dout),
      .o_empty (w_st_empty),
      .o_full  (w_st_full)
   );

   always_ff @(posedge clk_sys or negedge nRESET) begin
      if (!nRESET) r_st <= S_IDLE;
      else         r_st <= w_st_nxt;
   end

   always_comb begin
      w_st_nxt = r_st;
      case (r_st)
         S_IDLE:  if (w_trg)  w_st_nxt = S_BUSY;
         S_BUSY:  if (w_last) w_st_nxt = S_IDLE;
         default: w_st_nxt = S_IDLE;
      endcase
   end

   assign w_ifstat = {~w_cmdi, ~r_dtei, ~r_deci, 1'b1, ~w_busy, 1'b1, 1'b1, 1'b1};
   assign w_dbch   = 8'(r_dbc >> 8) | (r_dtei ? DTEI_MASK : 8'h00);

   always_comb begin
      w_rdata = 8'h00;
      case (r_ar)
         4'd0:    w_rdata = w_st_empty ? 8'h00 : w_st_dout;
         4'd1:    w_rdata = w_ifstat;
         4'd2:    w_rdata = r_dbc[7:0];
         4'd3:    w_rdata = w_dbch;
         4'd4:    w_rdata = r_head[7:0];
         4'd5:    w_rdata = r_head[15:8];
         4'd6:    w_rdata = r_head[23:16];
         4'd7:    w_rdata = r_head[31:24];
         4'd8:    w_rdata = 8'h04;
         4'd10:   w_rdata = r_wa[7:0];
         4'd11:   w_rdata = r_wa[15:8];
         4'd12:   w_rdata = 8'h80;
         4'd15:   w_rdata = {r_nvalst, 7'b0};
         default: w_rdata = 8'h00;
      endcase
   end

   // bus front end: strobe edge registers, address pointer, read latch
   always_ff @(posedge clk_sys or negedge nRESET) begin
      if (!nRESET) begin
         r_nwr_d <= 1'b1;
         r_nrd_d <= 1'b1;
         r_ar    <= 4'd0;
         r_dout  <= 8'h00;
      end else begin
         if (CLK_EN) begin
            r_nwr_d <= nWR;
            r_nrd_d <= nRD;
         end
         if (w_wr & ~RS)
            r_ar <= DIN[3:0];
         else if ((w_wr1 | w_rd1) & (r_ar != 4'd0))
            r_ar <= r_ar + 4'd1;
         if (w_rd)
            r_dout <= RS ? w_rdata : {4'b0, r_ar};
      end
   end

   always_ff @(posedge clk_sys or negedge nRESET) begin
      if (!nRESET) begin
         r_cmdien <= 1'b0;
         r_dteien <= 1'b0;
         r_decien <= 1'b0;
         r_douten <= 1'b0;
         r_decen  <= 1'b0;
         r_wa     <= 16'h0000;
      end else begin
         if (w_we[1]) begin
            r_cmdien <= DIN[7];
            r_dteien <= DIN[6];
            r_decien <= DIN[5];
            r_douten <= DIN[1];
         end
         if (w_we[8])  r_wa[7:0]  <= DIN;
         if (w_we[9])  r_wa[15:8] <= DIN;
         if (w_we[10]) r_decen    <= DIN[7];
      end
   end

   // DBC wraps to all-ones on the last byte, which is exactly a decrement from 0
   always_ff @(posedge clk_sys or negedge nRESET) begin
      if (!nRESET) begin
         r_dbc  <= '0;
         r_dac  <= 16'h0000;
         r_dtei <= 1'b0;
      end else begin
         if (w_stb) begin
            r_dbc <= r_dbc - DBC_W'(1);
            r_dac <= r_dac + 16'd1;
         end else if (!w_busy) begin
            if (w_we[2]) r_dbc[7:0]       <= DIN;
            if (w_we[3]) r_dbc[DBC_W-1:8] <= DIN[DBC_W-9:0];
            if (w_we[4]) r_dac[7:0]       <= DIN;
            if (w_we[5]) r_dac[15:8]      <= DIN;
         end
         if (w_last)       r_dtei <= 1'b1;
         else if (w_we[7]) r_dtei <= 1'b0;
      end
   end

   always_ff @(posedge clk_sys or negedge nRESET) begin
      if (!nRESET) begin
         r_sr_d   <= 1'b0;
         r_deci   <= 1'b0;
         r_nvalst <= 1'b1;
         r_cnt    <= '0;
         r_head   <= 32'h0;
      end else begin
         if (CLK_EN) r_sr_d <= SECTOR_READY;
         if (w_rise & r_decen) begin
            r_deci   <= 1'b1;
            r_nvalst <= 1'b0;
            r_cnt    <= '0;
            r_head   <= HEADER_DIN;
         end else begin
            if (CLK_EN & ~r_nvalst) begin
               if (r_cnt == CW'(INT_CYCLES - 1)) begin
                  r_nvalst <= 1'b1;
                  r_deci   <= 1'b0;
                  r_cnt    <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            if (w_rd1 & (r_ar == 4'd15)) r_deci <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge nRESET) begin
      if (!nRESET)     r_nirq <= 1'b1;
      else if (CLK_EN) r_nirq <= ~((w_cmdi & r_cmdien) | (r_dtei & r_dteien) | (r_deci & r_decien));
   end

   assign DOUT      = r_dout;
   assign XFER_ACT  = w_busy;
   assign XFER_ADDR = r_dac;
   assign CMD_VALID = ~w_cmd_empty;
   assign STAT_FULL = w_st_full;
   assign CDC_nIRQ  = r_nirq;
endmodule

// File: tb/tb_cdc_host_ctrl.sv
// Directed + randomized bench for cdc_host_ctrl with queue/arithmetic reference model.

module tb_cdc_host_ctrl;
   localparam int INT_CYCLES = 21600;
   localparam int CMD_DEPTH  = 8;
   localparam int STAT_DEPTH = 8;
   localparam int DBC_W      = 12;

   logic        clk_sys = 1'b0;
   logic        nRESET = 1'b0, CLK_EN = 1'b1, nWR = 1'b1, nRD = 1'b1, RS = 1'b0;
   logic [7:0]  DIN = 8'h00;
   logic [7:0]  DOUT;
   logic [31:0] HEADER_DIN = 32'h0;
   logic        SECTOR_READY = 1'b0, XFER_STB = 1'b0;
   logic        XFER_ACT;
   logic [15:0] XFER_ADDR;
   logic [7:0]  CMD_DOUT;
   logic        CMD_VALID;
   logic        CMD_POP = 1'b0;
   logic [7:0]  STAT_DIN = 8'h00;
   logic        STAT_PUSH = 1'b0;
   logic        STAT_FULL;
   logic        CDC_nIRQ;

   int n_cmp = 0, n_fail = 0;

   always #5 clk_sys = ~clk_sys;

   cdc_host_ctrl #(
      .INT_CYCLES(INT_CYCLES), .CMD_DEPTH(CMD_DEPTH),
      .STAT_DEPTH(STAT_DEPTH), .DBC_W(DBC_W)
   ) u_dut (
      .clk_sys(clk_sys), .nRESET(nRESET), .CLK_EN(CLK_EN), .nWR(nWR), .nRD(nRD),
      .RS(RS), .DIN(DIN), .DOUT(DOUT), .HEADER_DIN(HEADER_DIN),
      .SECTOR_READY(SECTOR_READY), .XFER_STB(XFER_STB), .XFER_ACT(XFER_ACT),
      .XFER_ADDR(XFER_ADDR), .CMD_DOUT(CMD_DOUT), .CMD_VALID(CMD_VALID),
      .CMD_POP(CMD_POP), .STAT_DIN(STAT_DIN), .STAT_PUSH(STAT_PUSH),
      .STAT_FULL(STAT_FULL), .CDC_nIRQ(CDC_nIRQ)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_wr(input logic rs, input logic [7:0] d);
      @(negedge clk_sys); RS = rs; DIN = d; nWR = 1'b0;
      @(negedge clk_sys); nWR = 1'b1;
   endtask

   task automatic bus_rd(input logic rs, output logic [7:0] d);
      @(negedge clk_sys); RS = rs; nRD = 1'b0;
      @(negedge clk_sys); d = DOUT; nRD = 1'b1;
   endtask

   task automatic wreg(input logic [3:0] a, input logic [7:0] d);
      bus_wr(1'b0, {4'b0, a});
      bus_wr(1'b1, d);
   endtask

   task automatic xstb();
      @(negedge clk_sys); XFER_STB = 1'b1;
      @(negedge clk_sys); XFER_STB = 1'b0;
   endtask

   task automatic stat_push(input logic [7:0] v);
      @(negedge clk_sys); STAT_DIN = v; STAT_PUSH = 1'b1;
      @(negedge clk_sys); STAT_PUSH = 1'b0;
   endtask

   task automatic cmd_pop();
      @(negedge clk_sys); CMD_POP = 1'b1;
      @(negedge clk_sys); CMD_POP = 1'b0;
   endtask

   // programs DBC/DAC through the auto-incrementing pointer, then DTTRG
   task automatic start_xfer(input logic [11:0] dbc, input logic [15:0] dac);
      bus_wr(1'b0, 8'd2);
      bus_wr(1'b1, dbc[7:0]);
      bus_wr(1'b1, {4'b0, dbc[11:8]});
      bus_wr(1'b1, dac[7:0]);
      bus_wr(1'b1, dac[15:8]);
      bus_wr(1'b1, 8'h00);
   endtask

   logic [7:0]  d, v, ex;
   logic [7:0]  wl, wh;
   logic [31:0] hdr;
   logic [11:0] dbc;
   logic [15:0] dac;
   logic [7:0]  cq[$];
   logic [7:0]  sq[$];
   logic [7:0]  sweep[16];
   int          n;

   initial begin
      // reset state
      repeat (3) @(negedge clk_sys);
      chk("rst_dout", DOUT, 8'h00);
      chk("rst_irq", CDC_nIRQ, 1'b1);
      chk("rst_act", XFER_ACT, 1'b0);
      chk("rst_addr", XFER_ADDR, 16'h0000);
      chk("rst_cmdv", CMD_VALID, 1'b0);
      chk("rst_sfull", STAT_FULL, 1'b0);
      nRESET = 1'b1;
      bus_rd(1'b0, d);  chk("rst_ar", d, 8'h00);
      bus_wr(1'b0, 8'h0B); bus_rd(1'b0, d); chk("ar_rd", d, 8'h0B);
      bus_wr(1'b0, 8'h01); bus_rd(1'b1, d); chk("rst_ifstat", d, 8'hFF);

      wl = 8'($urandom); wh = 8'($urandom);
      bus_wr(1'b0, 8'd8); bus_wr(1'b1, wl); bus_wr(1'b1, wh);

      // decoder IRQ
      wreg(4'd10, 8'h80);
      wreg(4'd1, 8'h20);
      HEADER_DIN = 32'h01000234;
      @(negedge clk_sys); SECTOR_READY = 1'b1;
      @(negedge clk_sys); SECTOR_READY = 1'b0;
      chk("dec_irq_lat", CDC_nIRQ, 1'b1);
      n = 0;
      for (int i = 0; i < 30000; i++) begin
         @(negedge clk_sys);
         if (CDC_nIRQ !== 1'b0) break;
         n++;
      end
      chk("dec_irq_len", n, INT_CYCLES);
      chk("dec_irq_rel", CDC_nIRQ, 1'b1);

      sweep = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h34, 8'h02, 8'h00, 8'h01,
                8'h04, 8'h00, wl, wh, 8'h80, 8'h00, 8'h00, 8'h80};
      bus_wr(1'b0, 8'd4);
      for (int a = 4; a < 16; a++) begin
         bus_rd(1'b1, d);
         chk($sformatf("sweep_r%0d", a), d, sweep[a]);
      end
      bus_rd(1'b0, d); chk("ar_wrap", d, 8'h00);

      // transfer end
      wreg(4'd1, 8'h42);
      start_xfer(12'h003, 16'h1000);
      chk("x_act", XFER_ACT, 1'b1);
      repeat (4) xstb();
      chk("x_addr", XFER_ADDR, 16'h1004);
      chk("x_done", XFER_ACT, 1'b0);
      @(negedge clk_sys);
      chk("x_irq", CDC_nIRQ, 1'b0);
      bus_wr(1'b0, 8'd2);
      bus_rd(1'b1, d); chk("x_dbcl", d, 8'hFF);
      bus_rd(1'b1, d); chk("x_dbch", d, 8'hFF);
      bus_wr(1'b0, 8'd1); bus_rd(1'b1, d); chk("x_ifstat", d, 8'hBF);
      wreg(4'd7, 8'h00);
      repeat (2) @(negedge clk_sys);
      chk("x_ack_irq", CDC_nIRQ, 1'b1);
      bus_wr(1'b0, 8'd3); bus_rd(1'b1, d); chk("x_dbch_ack", d, 8'h0F);

      // randomized transfers: DBC+1 bytes, DAC wraps at 16 bits
      for (int t = 0; t < 4; t++) begin
         dbc = (t == 0) ? 12'd0 : 12'($urandom_range(1, 12));
         dac = (t == 1) ? 16'hFFFE : 16'($urandom);
         start_xfer(dbc, dac);
         repeat (int'(dbc)) xstb();
         chk($sformatf("rx%0d_act", t), XFER_ACT, 1'b1);
         chk($sformatf("rx%0d_mid", t), XFER_ADDR, 16'(dac + dbc));
         xstb();
         chk($sformatf("rx%0d_done", t), XFER_ACT, 1'b0);
         chk($sformatf("rx%0d_addr", t), XFER_ADDR, 16'(dac + dbc + 16'd1));
         xstb();
         chk($sformatf("rx%0d_idle", t), XFER_ADDR, 16'(dac + dbc + 16'd1));
         bus_wr(1'b0, 8'd2);
         bus_rd(1'b1, d); chk($sformatf("rx%0d_dbcl", t), d, 8'hFF);
         wreg(4'd7, 8'h00);
      end

      // DTTRG and DBC write while busy are ignored
      start_xfer(12'h005, 16'h2000);
      repeat (2) xstb();
      bus_wr(1'b0, 8'd2); bus_wr(1'b1, 8'h3F);
      bus_wr(1'b0, 8'd6); bus_wr(1'b1, 8'h00);
      repeat (3) xstb();
      chk("busy_act", XFER_ACT, 1'b1);
      xstb();
      chk("busy_done", XFER_ACT, 1'b0);
      chk("busy_addr", XFER_ADDR, 16'h2006);
      wreg(4'd7, 8'h00);

      wreg(4'd1, 8'h40);
      bus_wr(1'b0, 8'd6); bus_wr(1'b1, 8'h00);
      @(negedge clk_sys);
      chk("nodouten", XFER_ACT, 1'b0);

      // command FIFO overflow then random traffic
      bus_wr(1'b0, 8'd0);
      for (int i = 0; i < 9; i++) begin
         v = 8'($urandom);
         bus_wr(1'b1, v);
         if (cq.size() < CMD_DEPTH) cq.push_back(v);
      end
      chk("cmd_valid", CMD_VALID, 1'b1);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("cmd_pop%0d", i), CMD_DOUT, cq.pop_front());
         cmd_pop();
      end
      chk("cmd_empty", CMD_VALID, 1'b0);
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            v = 8'($urandom);
            bus_wr(1'b1, v);
            if (cq.size() < CMD_DEPTH) cq.push_back(v);
         end else begin
            cmd_pop();
            if (cq.size() > 0) void'(cq.pop_front());
         end
         chk($sformatf("cmd_rv%0d", i), CMD_VALID, cq.size() != 0);
         if (cq.size() != 0) chk($sformatf("cmd_rd%0d", i), CMD_DOUT, cq[0]);
      end

      // status FIFO
      wreg(4'd1, 8'h80);
      stat_push(8'hA5);
      @(negedge clk_sys);
      chk("st_irq", CDC_nIRQ, 1'b0);
      bus_wr(1'b0, 8'd1); bus_rd(1'b1, d); chk("st_cmdi", d[7], 1'b0);
      bus_wr(1'b0, 8'd0); bus_rd(1'b1, d); chk("st_sbout", d, 8'hA5);
      repeat (2) @(negedge clk_sys);
      chk("st_irq_rel", CDC_nIRQ, 1'b1);
      bus_rd(1'b1, d); chk("st_empty_rd", d, 8'h00);
      for (int i = 0; i < 9; i++) begin
         v = 8'($urandom);
         stat_push(v);
         if (sq.size() < STAT_DEPTH) sq.push_back(v);
      end
      chk("st_full", STAT_FULL, 1'b1);
      for (int i = 0; i < 60; i++) begin
         int op;
         op = (i == 0) ? 2 : int'($urandom_range(0, 2));
         v = 8'($urandom);
         if (op == 0) begin
            stat_push(v);
            if (sq.size() < STAT_DEPTH) sq.push_back(v);
         end else begin
            @(negedge clk_sys); RS = 1'b1; nRD = 1'b0;
            if (op == 2) begin STAT_DIN = v; STAT_PUSH = 1'b1; end
            @(negedge clk_sys); d = DOUT; nRD = 1'b1; STAT_PUSH = 1'b0;
            ex = (sq.size() > 0) ? sq.pop_front() : 8'h00;
            if (op == 2 && sq.size() < STAT_DEPTH) sq.push_back(v);
            chk($sformatf("st_rd%0d", i), d, ex);
         end
         chk($sformatf("st_fl%0d", i), STAT_FULL, sq.size() == STAT_DEPTH);
      end
      while (sq.size() > 0) begin
         bus_rd(1'b1, d);
         chk("st_drain", d, sq.pop_front());
      end
      chk("st_drained", STAT_FULL, 1'b0);

      // sector rise coincident with the STAT3 read: set wins
      hdr = $urandom;
      HEADER_DIN = hdr;
      bus_wr(1'b0, 8'd15);
      @(negedge clk_sys); RS = 1'b1; nRD = 1'b0; SECTOR_READY = 1'b1;
      @(negedge clk_sys); d = DOUT; nRD = 1'b1; SECTOR_READY = 1'b0;
      chk("col_stat3", d, 8'h80);
      bus_wr(1'b0, 8'd1); bus_rd(1'b1, d); chk("col_deci", d[5], 1'b0);
      bus_wr(1'b0, 8'd15); bus_rd(1'b1, d); chk("col_nvalst", d, 8'h00);
      bus_wr(1'b0, 8'd1); bus_rd(1'b1, d); chk("col_deci_clr", d[5], 1'b1);
      bus_wr(1'b0, 8'd4);
      for (int b = 0; b < 4; b++) begin
         bus_rd(1'b1, d);
         chk($sformatf("col_head%0d", b), d, hdr[8*b +: 8]);
      end

      // no state advance with CLK_EN low
      CLK_EN = 1'b0;
      stat_push(8'h5A);
      bus_wr(1'b0, 8'd3);
      CLK_EN = 1'b1;
      bus_rd(1'b0, d); chk("clken_ar", d, 8'h08);
      bus_wr(1'b0, 8'd1); bus_rd(1'b1, d); chk("clken_cmdi", d[7], 1'b1);

      // async reset mid-transfer
      wreg(4'd1, 8'hC2);
      start_xfer(12'd10, 16'h3000);
      repeat (3) xstb();
      stat_push(8'h11);
      bus_wr(1'b0, 8'd1);
      bus_rd(1'b0, d);
      chk("ar_pre_dout", d, 8'h01);
      chk("ar_pre_irq", CDC_nIRQ, 1'b0);
      chk("ar_pre_act", XFER_ACT, 1'b1);
      #2 nRESET = 1'b0;
      #1;
      chk("ar_irq", CDC_nIRQ, 1'b1);
      chk("ar_act", XFER_ACT, 1'b0);
      chk("ar_dout", DOUT, 8'h00);
      chk("ar_addr", XFER_ADDR, 16'h0000);
      @(negedge clk_sys); nRESET = 1'b1;
      repeat (12) xstb();
      chk("ar_noxfer", XFER_ADDR, 16'h0000);
      bus_wr(1'b0, 8'd1); bus_rd(1'b1, d); chk("ar_ifstat", d, 8'hFF);
      chk("ar_irq_post", CDC_nIRQ, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
